datapath: RTL and testbench

Register-file and ALU datapath driven by the instruction controller's control word. It holds sixteen 16-bit general registers and selects write-back data from the ALU, data-memory read data or the instruction's 8-bit constant. It supplies the Rp zero status that the controller samples in its jump state, and store data to data memory. The block sits directly downstream of the controller and beside data memory.

---
 rtl/datapath_pkg.sv | 31 +++
 rtl/datapath_if.sv | 40 ++++
 rtl/datapath_register_file.sv | 54 +++++
 rtl/datapath.sv | 121 ++++++++++++
 tb/tb_datapath.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the register-file / ALU datapath: default widths,
// ALU operation and write-back source encodings, and a small decode helper.
package datapath_pkg;

  localparam int DP_DATA_W  = 16;
  localparam int DP_ADDR_W  = 4;
  localparam int DP_CONST_W = 8;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_AND  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU   = 2'b00,
    WB_MEM   = 2'b01,
    WB_CONST = 2'b10,
    WB_RSVD  = 2'b11
  } wb_src_e;

  // Only arithmetic operations produce meaningful carry/overflow status.
  function automatic logic op_sets_flags(input alu_op_e op);
    case (op)
      ALU_ADD, ALU_SUB: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Control-word and status bundle between the instruction controller (master)
// and the datapath (slave). Data-memory read/store data ride along as well.
interface datapath_if
  import datapath_pkg::*;
#(
  parameter int DATA_W  = DP_DATA_W,
  parameter int ADDR_W  = DP_ADDR_W,
  parameter int CONST_W = DP_CONST_W
);

  logic [CONST_W-1:0] RF_W_data;
  logic [DATA_W-1:0]  D_R_data;
  logic               RF_s1;
  logic               RF_s0;
  logic [ADDR_W-1:0]  RF_W_addr;
  logic               RF_W_wr;
  logic [ADDR_W-1:0]  RF_Rp_addr;
  logic [ADDR_W-1:0]  RF_Rq_addr;
  logic               RF_Rp_rd;
  logic               RF_Rq_rd;
  logic               alu_s1;
  logic               alu_s0;
  logic               RF_RP_zero;
  logic [DATA_W-1:0]  D_W_data;
  logic               flag_c;
  logic               flag_v;

  modport master (
    output RF_W_data, D_R_data, RF_s1, RF_s0, RF_W_addr, RF_W_wr,
           RF_Rp_addr, RF_Rq_addr, RF_Rp_rd, RF_Rq_rd, alu_s1, alu_s0,
    input  RF_RP_zero, D_W_data, flag_c, flag_v
  );

  modport slave (
    input  RF_W_data, D_R_data, RF_s1, RF_s0, RF_W_addr, RF_W_wr,
           RF_Rp_addr, RF_Rq_addr, RF_Rp_rd, RF_Rq_rd, alu_s1, alu_s0,
    output RF_RP_zero, D_W_data, flag_c, flag_v
  );

endinterface

// File: rtl/datapath_register_file.sv
// General-purpose register file: 2^ADDR_W x DATA_W storage, asynchronous
// clear, one synchronous write port and two gated combinational read ports.
// Reads see the pre-edge contents; there is no write-to-read bypass.
module register_file
  import datapath_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic              p_rd,
  input  logic [ADDR_W-1:0] q_addr,
  input  logic              q_rd,
  output logic [DATA_W-1:0] p_data,
  output logic [DATA_W-1:0] q_data
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_r [NREGS];

  // Storage: cleared asynchronously, one write per rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (w_en) begin
      regs_r[w_addr] <= w_data;
    end
  end

  // Read ports: disabled ports return zero rather than stale data.
  always_comb begin
    p_data = {DATA_W{1'b0}};
    q_data = {DATA_W{1'b0}};
    if (p_rd) begin
      p_data = regs_r[p_addr];
    end else begin
      p_data = {DATA_W{1'b0}};
    end
    if (q_rd) begin
      q_data = regs_r[q_addr];
    end else begin
      q_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/datapath.sv
// Register-file + ALU datapath driven by the controller's control word.
// Write-back selects ALU result, memory read data or the zero-extended
// instruction constant; Rp read data doubles as store data and zero status.
module datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W  = DP_DATA_W,
  parameter int ADDR_W  = DP_ADDR_W,
  parameter int CONST_W = DP_CONST_W
) (
  input  logic      clk,
  input  logic      reset,
  datapath_if.slave bus
);

  alu_op_e           alu_op_s;
  wb_src_e           wb_src_s;
  logic [DATA_W-1:0] rp_data_s;
  logic [DATA_W-1:0] rq_data_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W:0]   diff_s;
  logic [DATA_W-1:0] alu_res_s;
  logic [DATA_W-1:0] wb_data_s;
  logic              we_s;
  logic              flag_upd_s;
  logic              c_next_s;
  logic              v_next_s;
  logic              flag_c_r;
  logic              flag_v_r;

  assign alu_op_s = alu_op_e'({bus.alu_s1, bus.alu_s0});
  assign wb_src_s = wb_src_e'({bus.RF_s1, bus.RF_s0});

  register_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk    (clk),
    .reset  (reset),
    .w_en   (we_s),
    .w_addr (bus.RF_W_addr),
    .w_data (wb_data_s),
    .p_addr (bus.RF_Rp_addr),
    .p_rd   (bus.RF_Rp_rd),
    .q_addr (bus.RF_Rq_addr),
    .q_rd   (bus.RF_Rq_rd),
    .p_data (rp_data_s),
    .q_data (rq_data_s)
  );

  // Extended add/subtract so the top bit carries carry-out / borrow.
  assign sum_s  = {1'b0, rp_data_s} + {1'b0, rq_data_s};
  assign diff_s = {1'b0, rp_data_s} - {1'b0, rq_data_s};

  // ALU result, wrapped to DATA_W.
  always_comb begin
    alu_res_s = rp_data_s;
    case (alu_op_s)
      ALU_PASS: alu_res_s = rp_data_s;
      ALU_ADD:  alu_res_s = sum_s[DATA_W-1:0];
      ALU_SUB:  alu_res_s = diff_s[DATA_W-1:0];
      ALU_AND:  alu_res_s = rp_data_s & rq_data_s;
      default:  alu_res_s = rp_data_s;
    endcase
  end

  // Write-back source mux; the reserved source also suppresses the write.
  always_comb begin
    wb_data_s = {DATA_W{1'b0}};
    we_s      = 1'b0;
    case (wb_src_s)
      WB_ALU:   wb_data_s = alu_res_s;
      WB_MEM:   wb_data_s = bus.D_R_data;
      WB_CONST: wb_data_s = {{(DATA_W-CONST_W){1'b0}}, bus.RF_W_data};
      default:  wb_data_s = {DATA_W{1'b0}};
    endcase
    if (bus.RF_W_wr && (wb_src_s != WB_RSVD)) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Next carry/borrow and signed overflow for the current arithmetic op.
  always_comb begin
    c_next_s   = 1'b0;
    v_next_s   = 1'b0;
    flag_upd_s = 1'b0;
    if (alu_op_s == ALU_ADD) begin
      c_next_s = sum_s[DATA_W];
      v_next_s = (rp_data_s[DATA_W-1] == rq_data_s[DATA_W-1]) &&
                 (sum_s[DATA_W-1] != rp_data_s[DATA_W-1]);
    end else begin
      c_next_s = diff_s[DATA_W];
      v_next_s = (rp_data_s[DATA_W-1] != rq_data_s[DATA_W-1]) &&
                 (diff_s[DATA_W-1] != rp_data_s[DATA_W-1]);
    end
    if (bus.RF_W_wr && (wb_src_s == WB_ALU) && op_sets_flags(alu_op_s)) begin
      flag_upd_s = 1'b1;
    end else begin
      flag_upd_s = 1'b0;
    end
  end

  // Status flags: captured only on an arithmetic ALU write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_c_r <= 1'b0;
      flag_v_r <= 1'b0;
    end else if (flag_upd_s) begin
      flag_c_r <= c_next_s;
      flag_v_r <= v_next_s;
    end
  end

  assign bus.RF_RP_zero = (rp_data_s == {DATA_W{1'b0}});
  assign bus.D_W_data   = rp_data_s;
  assign bus.flag_c     = flag_c_r;
  assign bus.flag_v     = flag_v_r;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: the driver pushes the expected outputs from a
// behavioural register/flag model; a negedge monitor pops and compares.
module tb_datapath;
  import datapath_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  datapath_if bus ();

  datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] dw;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned mreg[16];
  bit          mc = 1'b0;
  bit          mv = 1'b0;

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mreg[i] = 0;
    mc = 1'b0;
    mv = 1'b0;
  endfunction

  function automatic int unsigned rp_val();
    return bus.RF_Rp_rd ? mreg[bus.RF_Rp_addr] : 0;
  endfunction

  function automatic int unsigned rq_val();
    return bus.RF_Rq_rd ? mreg[bus.RF_Rq_addr] : 0;
  endfunction

  function automatic int to_signed(input int unsigned x);
    return (x >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  task automatic drive(input logic [3:0] pa, input logic prd,
                       input logic [3:0] qa, input logic qrd,
                       input logic [1:0] op, input logic [1:0] src,
                       input logic [3:0] wa, input logic wr,
                       input logic [7:0] k, input logic [15:0] mem);
    bus.RF_Rp_addr = pa;
    bus.RF_Rp_rd   = prd;
    bus.RF_Rq_addr = qa;
    bus.RF_Rq_rd   = qrd;
    {bus.alu_s1, bus.alu_s0} = op;
    {bus.RF_s1, bus.RF_s0}   = src;
    bus.RF_W_addr  = wa;
    bus.RF_W_wr    = wr;
    bus.RF_W_data  = k;
    bus.D_R_data   = mem;
  endtask

  task automatic expect_now(input string tag);
    exp_t e;
    e.tag = tag;
    e.dw  = 16'(rp_val());
    e.z   = (rp_val() == 0);
    e.c   = mc;
    e.v   = mv;
    sb_q.push_back(e);
  endtask

  // Advance one clock; apply the architectural effect of the current control word.
  task automatic step();
    int unsigned a, b, res, val;
    int          sres;
    logic [1:0]  op, src;
    bit          nc, nv;
    a = rp_val();
    b = rq_val();
    op = {bus.alu_s1, bus.alu_s0};
    src = {bus.RF_s1, bus.RF_s0};
    nc = 1'b0;
    nv = 1'b0;
    case (op)
      2'd0: res = a;
      2'd1: begin
        res  = (a + b) % 65536;
        nc   = (a + b) > 65535;
        sres = to_signed(a) + to_signed(b);
        nv   = (sres > 32767) || (sres < -32768);
      end
      2'd2: begin
        res  = (a + 65536 - b) % 65536;
        nc   = a < b;
        sres = to_signed(a) - to_signed(b);
        nv   = (sres > 32767) || (sres < -32768);
      end
      default: res = a & b;
    endcase
    case (src)
      2'd0: val = res;
      2'd1: val = bus.D_R_data;
      default: val = bus.RF_W_data;
    endcase
    @(posedge clk);
    if (reset && bus.RF_W_wr && src != 2'd3) begin
      mreg[bus.RF_W_addr] = val;
      if (src == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
        mc = nc;
        mv = nv;
      end
    end
    #1;
  endtask

  task automatic rd(input logic [3:0] pa, input string tag);
    drive(pa, 1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 8'h00, 16'h0000);
    expect_now(tag);
    step();
  endtask

  task automatic wr_mem(input logic [3:0] wa, input logic [15:0] d, input string tag);
    drive(4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd1, wa, 1'b1, 8'h00, d);
    expect_now(tag);
    step();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, ".D_W_data"},   bus.D_W_data, e.dw);
      chk({e.tag, ".RF_RP_zero"}, {15'd0, bus.RF_RP_zero}, {15'd0, e.z});
      chk({e.tag, ".flag_c"},     {15'd0, bus.flag_c}, {15'd0, e.c});
      chk({e.tag, ".flag_v"},     {15'd0, bus.flag_v}, {15'd0, e.v});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2;
    model_clear();
    drive(4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 8'h00, 16'h0000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    expect_now("reset_state");
    step();
    reset = 1'b1;

    // Load constant
    drive(4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd2, 4'd3, 1'b1, 8'hA5, 16'h0000);
    expect_now("ldc_wr");
    step();
    rd(4'd3, "ldc_rd");

    // Add overflow
    wr_mem(4'd1, 16'h7FFF, "set_r1");
    wr_mem(4'd2, 16'h0001, "set_r2");
    drive(4'd1, 1'b1, 4'd2, 1'b1, 2'd1, 2'd0, 4'd4, 1'b1, 8'h00, 16'h0000);
    expect_now("add_wr");
    step();
    rd(4'd4, "add_ovf_rd");

    // Subtract borrow/wrap, then self-subtract to zero
    wr_mem(4'd1, 16'h0000, "set_r1z");
    wr_mem(4'd2, 16'h0001, "set_r2b");
    drive(4'd1, 1'b1, 4'd2, 1'b1, 2'd2, 2'd0, 4'd5, 1'b1, 8'h00, 16'h0000);
    expect_now("sub_wr");
    step();
    rd(4'd5, "sub_borrow_rd");
    drive(4'd1, 1'b1, 4'd1, 1'b1, 2'd2, 2'd0, 4'd6, 1'b1, 8'h00, 16'h0000);
    expect_now("sub_self_wr");
    step();
    rd(4'd6, "sub_zero_rd");

    // Memory load and reserved source
    wr_mem(4'd7, 16'h1234, "mem_wr");
    rd(4'd7, "mem_rd");
    drive(4'd7, 1'b1, 4'd7, 1'b1, 2'd1, 2'd3, 4'd7, 1'b1, 8'hFF, 16'hFFFF);
    expect_now("rsvd_wr");
    step();
    rd(4'd7, "rsvd_rd");

    // Read/write collision: old value this cycle, new value next
    wr_mem(4'd2, 16'h0005, "coll_set");
    drive(4'd2, 1'b1, 4'd0, 1'b0, 2'd0, 2'd1, 4'd2, 1'b1, 8'h00, 16'h0009);
    expect_now("coll_same");
    step();
    rd(4'd2, "coll_next");

    // Asynchronous reset between edges aborts the pending write
    wr_mem(4'd8, 16'hBEEF, "rst_set");
    drive(4'd8, 1'b1, 4'd0, 1'b0, 2'd0, 2'd1, 4'd8, 1'b1, 8'h00, 16'h1111);
    #2;
    reset = 1'b0;
    model_clear();
    expect_now("rst_async");
    step();
    reset = 1'b1;
    rd(4'd8, "rst_r8");
    rd(4'd7, "rst_r7");

    // Randomized traffic, with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      drive(r1[3:0], r1[4] | r1[5], r1[9:6], r1[10] | r1[11], r1[13:12],
            r1[15:14], r1[19:16], r1[20] | r1[21], r1[29:22], r2[15:0]);
      if (r2[21:16] == 6'd0) begin
        #2;
        reset = 1'b0;
        model_clear();
        expect_now("rnd_rst");
        step();
        reset = 1'b1;
      end else begin
        expect_now("rnd");
        step();
      end
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
